// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the four-requester round-robin mux arbiter.
// Pure declarations: no latency and no flow control of its own.
package mux4_arb_pkg;

  localparam int NUM_REQ           = 4;
  localparam int DEFAULT_BURST_LEN = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Round-robin pointer advance; the 2-bit add wraps requester 3 back to 0.
  function automatic logic [1:0] next_ptr(input logic [1:0] cur);
    return cur + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... mod 4.
// Zero latency; no flow control (a pure function of its inputs).
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic               any_o,
  output logic [1:0]         idx_o
);

  logic [1:0] cand;

  // Scanning from the farthest offset down lets the nearest hit overwrite the others.
  always_comb begin
    any_o = 1'b0;
    idx_o = ptr_i;
    cand  = ptr_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr_i + 2'(k);
      if (req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin burst arbiter driving a 4:1 mux into one registered valid/ready output stage.
// Grant one cycle after request, data one cycle after transfer; out_ready low drops in_ready[sel] combinationally.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int SEL_WIDTH = 2,
  parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   in_valid,
  input  logic [WIDTH-1:0]     in_data0,
  input  logic [WIDTH-1:0]     in_data1,
  input  logic [WIDTH-1:0]     in_data2,
  input  logic [WIDTH-1:0]     in_data3,
  output logic [NUM_REQ-1:0]   in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 grant_active
);

  localparam int              CNT_W     = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  arb_state_e       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             pick_any;
  logic [1:0]       pick_idx;
  logic             out_free;
  logic             xfer;
  logic [WIDTH-1:0] mux_dat;

  rr_pick4 u_pick (
    .req_i (in_valid),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_comb begin
    case (sel_q)
      2'd0:    mux_dat = in_data0;
      2'd1:    mux_dat = in_data1;
      2'd2:    mux_dat = in_data2;
      default: mux_dat = in_data3;
    endcase
  end

  // The output register can take a beat if it is empty or being drained this cycle.
  assign out_free = !out_valid_q || out_ready;
  assign xfer     = (state_q == GRANT) && in_valid[sel_q] && out_free;

  always_comb begin
    in_ready = '0;
    if (state_q == GRANT && out_free) begin
      in_ready[sel_q] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d      = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!in_valid[sel_q]) begin
          state_d = IDLE;
          ptr_d   = next_ptr(sel_q);
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            ptr_d   = next_ptr(sel_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_dat;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      sel_q      <= 2'd0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign sel          = sel_q;
  assign grant_active = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: default BURST_LEN=4 instance plus a BURST_LEN=1 instance.
// Inputs change 1ns after the rising edge; registered outputs are sampled there too.
module tb_mux4_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid, b_in_valid;
  logic [15:0] d0, d1, d2, d3;
  logic        out_ready, b_out_ready;

  logic [3:0]  in_ready, b_in_ready;
  logic        out_valid, b_out_valid;
  logic [15:0] out_data, b_out_data;
  logic [1:0]  sel, b_sel;
  logic        grant_active, b_grant_active;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [15:0] held;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.WIDTH(16), .SEL_WIDTH(2), .BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_data0(d0), .in_data1(d1), .in_data2(d2), .in_data3(d3),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .sel(sel), .grant_active(grant_active)
  );

  mux4_rr_arbiter #(.WIDTH(16), .SEL_WIDTH(2), .BURST_LEN(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid),
    .in_data0(d0), .in_data1(d1), .in_data2(d2), .in_data3(d3),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(b_out_ready), .sel(b_sel), .grant_active(b_grant_active)
  );

  // Requester i presents {i, cycle number}, so each captured beat names its source and cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    d0 = {4'h0, cyc[11:0]};
    d1 = {4'h1, cyc[11:0]};
    d2 = {4'h2, cyc[11:0]};
    d3 = {4'h3, cyc[11:0]};
  endtask

  function automatic logic [15:0] beat(input logic [3:0] req);
    int c;
    c = cyc - 1;
    return {req, c[11:0]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'hF; b_in_valid = 4'h0; out_ready = 1'b1; b_out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
    checks++; if (grant_active !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b want 0", grant_active); end
    checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    in_valid = 4'h0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    in_valid = 4'b0100;
    tick();
    checks++; if (sel !== 2'd2 || grant_active !== 1'b1) begin errors++; $display("FAIL single_grant: got sel=%0d ga=%b want sel=2 ga=1", sel, grant_active); end
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_in_ready: got %b want 0100", in_ready); end
    for (int b = 0; b < 3; b++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== beat(4'h2)) begin errors++; $display("FAIL single_beat%0d: got v=%b d=%h want v=1 d=%h", b, out_valid, out_data, beat(4'h2)); end
    end
    in_valid = 4'b0000;
    tick();
    checks++; if (grant_active !== 1'b0 || out_valid !== 1'b0 || in_ready !== 4'h0) begin errors++; $display("FAIL single_release: got ga=%b v=%b rdy=%b want 0 0 0000", grant_active, out_valid, in_ready); end
  endtask

  task automatic test_wrap();
    // Pointer should now be 3, so 3 wins over 2.
    in_valid = 4'b1100;
    tick();
    checks++; if (sel !== 2'd3) begin errors++; $display("FAIL wrap_ptr3: got sel=%0d want 3", sel); end
    in_valid = 4'b1001;
    for (int b = 0; b < 4; b++) begin
      tick();
      checks++; if (out_data !== beat(4'h3) || grant_active !== (b < 3)) begin errors++; $display("FAIL wrap_beat%0d: got d=%h ga=%b want d=%h ga=%b", b, out_data, grant_active, beat(4'h3), (b < 3)); end
    end
    tick();
    checks++; if (sel !== 2'd0 || grant_active !== 1'b1) begin errors++; $display("FAIL wrap_to0: got sel=%0d ga=%b want sel=0 ga=1", sel, grant_active); end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_reset_midburst();
    in_valid = 4'b0100;
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b1 || out_data !== beat(4'h2)) begin errors++; $display("FAIL midrst_pre: got v=%b d=%h want v=1 d=%h", out_valid, out_data, beat(4'h2)); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || grant_active !== 1'b0 || in_ready !== 4'h0) begin errors++; $display("FAIL midrst_async: got v=%b ga=%b rdy=%b want 0 0 0000", out_valid, grant_active, in_ready); end
    checks++; if (out_data !== 16'h0 || sel !== 2'd0) begin errors++; $display("FAIL midrst_regs: got d=%h sel=%0d want 0000 0", out_data, sel); end
    tick();
    rst_n = 1'b1;
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_rotation();
    in_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      checks++; if (sel !== 2'(g % 4) || grant_active !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rot_grant%0d: got sel=%0d ga=%b v=%b want sel=%0d ga=1 v=0", g, sel, grant_active, out_valid, g % 4); end
      for (int b = 0; b < 4; b++) begin
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== beat(4'(g % 4)) || grant_active !== (b < 3)) begin errors++; $display("FAIL rot_g%0d_b%0d: got v=%b d=%h ga=%b want v=1 d=%h ga=%b", g, b, out_valid, out_data, grant_active, beat(4'(g % 4)), (b < 3)); end
      end
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    in_valid = 4'b0010;
    tick(); tick(); tick();
    held = beat(4'h1);
    checks++; if (out_data !== held) begin errors++; $display("FAIL bp_pre: got %h want %h", out_data, held); end
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      #1;
      checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL bp_rdy%0d: got %b want 0000", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== held || grant_active !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got v=%b d=%h ga=%b want v=1 d=%h ga=1", i, out_valid, out_data, grant_active, held); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_resume_rdy: got %b want 0010", in_ready); end
    tick();
    checks++; if (out_data !== beat(4'h1) || grant_active !== 1'b1) begin errors++; $display("FAIL bp_beat3: got d=%h ga=%b want d=%h ga=1", out_data, grant_active, beat(4'h1)); end
    tick();
    checks++; if (out_data !== beat(4'h1) || grant_active !== 1'b0) begin errors++; $display("FAIL bp_beat4: got d=%h ga=%b want d=%h ga=0", out_data, grant_active, beat(4'h1)); end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_burst1();
    b_in_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      checks++; if (b_sel !== 2'(g % 4) || b_grant_active !== 1'b1 || b_in_ready !== 4'(1 << (g % 4))) begin errors++; $display("FAIL b1_grant%0d: got sel=%0d ga=%b rdy=%b want sel=%0d ga=1", g, b_sel, b_grant_active, b_in_ready, g % 4); end
      tick();
      checks++; if (b_out_valid !== 1'b1 || b_out_data !== beat(4'(g % 4)) || b_grant_active !== 1'b0) begin errors++; $display("FAIL b1_beat%0d: got v=%b d=%h ga=%b want v=1 d=%h ga=0", g, b_out_valid, b_out_data, b_grant_active, beat(4'(g % 4))); end
    end
    b_in_valid = 4'b0000;
    tick();
  endtask

  initial begin
    d0 = 16'h0; d1 = 16'h0; d2 = 16'h0; d3 = 16'h0;
    held = 16'h0;
    test_reset();
    test_single();
    test_wrap();
    test_reset_midburst();
    test_rotation();
    test_backpressure();
    test_burst1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
